avalon_onchip_ram_clr: RTL and testbench

Parametrised Avalon-MM single-port on-chip RAM slave, successor to the fixed 32x1024 on-chip memory in soc_system. Adds configurable width/depth, pipelined reads (readdatavalid, latency 1 or 2), waitrequest flow control, and a hardware clear engine. The clear engine fills the array with CLEAR_VALUE after reset or on request. Sits on the HPS/FPGA lightweight bridge as a scratch/framebuffer memory for the loading-bar design.

---
 rtl/avalon_ram_pkg.sv | 25 ++
 rtl/ram_be_array.sv | 31 +++
 rtl/avalon_onchip_ram_clr.sv | 143 ++++++++++++++
 tb/tb_avalon_onchip_ram_clr.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_ram_pkg.sv
// Shared types and elaboration helpers for the Avalon-MM on-chip RAM with clear engine.
package avalon_ram_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Byte-lane count for a given data width (BE_W = DATA_W/8).
  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/ram_be_array.sv
// Byte-enabled single write port / single registered read port RAM, block-RAM inferable.
module ram_be_array #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++) begin
      if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // Read register holds between reads so the bus sees a stable readdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/avalon_onchip_ram_clr.sv
// Avalon-MM single-port on-chip RAM slave with pipelined reads and a hardware clear engine.
module avalon_onchip_ram_clr
  import avalon_ram_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 10,
  parameter int                DEPTH          = 1024,
  parameter int                READ_LATENCY   = 1,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic [DATA_W/8-1:0]     byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_W-1:0]       writedata,
  output logic [DATA_W-1:0]       readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  input  logic                    clear_req,
  output logic                    clear_busy
);

  localparam int                BE_W      = be_w(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam state_t            RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
    $error("avalon_onchip_ram_clr: READ_LATENCY must be 1 or 2");
  end
  if ((DATA_W % 8) != 0 || DEPTH < 2 || clog2(DEPTH) > ADDR_W) begin : g_bad_geometry
    $error("avalon_onchip_ram_clr: illegal DATA_W/DEPTH/ADDR_W combination");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic              busy, accept, wr_acc, rd_acc, in_range;
  logic [BE_W-1:0]   ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_q, rdata_p0;
  logic              vld_p0, oor_p0;

  // busy decodes the state flop directly, so waitrequest has no input-to-output path.
  assign busy        = (state == S_CLEAR);
  assign waitrequest = busy;
  assign clear_busy  = busy;

  assign accept   = chipselect & (read | write) & ~busy;
  assign wr_acc   = accept & write;
  assign rd_acc   = accept & read & ~write;
  assign in_range = ({1'b0, address} < (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RST_STATE;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    if (state == S_CLEAR) begin
      if (clr_addr == LAST_ADDR) begin
        state_nxt    = S_IDLE;
        clr_addr_nxt = '0;
      end else begin
        clr_addr_nxt = clr_addr + 1'b1;
      end
    end else if (clear_req) begin
      state_nxt = S_CLEAR;
    end
  end

  // The clear engine owns the write port while busy; bus transfers are stalled then.
  always_comb begin
    ram_we    = (wr_acc && in_range) ? byteenable : '0;
    ram_waddr = address;
    ram_wdata = writedata;
    if (busy) begin
      ram_we    = '1;
      ram_waddr = clr_addr;
      ram_wdata = CLEAR_VALUE;
    end
  end

  ram_be_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .re      (rd_acc & in_range),
    .raddr   (address),
    .rdata   (ram_q)
  );

  // Stage p0: array read register plus out-of-range flag captured at accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
      oor_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_acc;
      if (rd_acc) oor_p0 <= ~in_range;
    end
  end

  assign rdata_p0 = oor_p0 ? '0 : ram_q;

  if (READ_LATENCY == 2) begin : g_lat2
    logic              vld_p1;
    logic [DATA_W-1:0] rdata_p1;

    // Stage p1: extra output register for timing closure.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vld_p1   <= 1'b0;
        rdata_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) rdata_p1 <= rdata_p0;
      end
    end

    assign readdata      = rdata_p1;
    assign readdatavalid = vld_p1;
  end else begin : g_lat1
    assign readdata      = rdata_p0;
    assign readdatavalid = vld_p0;
  end

endmodule

// File: tb/tb_avalon_onchip_ram_clr.sv
// Directed bench: dut0 = 16 words/latency 1/clear 0, dut1 = 12 words/latency 2/clear 0x12345678.
module tb_avalon_onchip_ram_clr;

  logic        clk;
  logic        reset_n;
  logic [3:0]  addr  [2];
  logic [3:0]  be    [2];
  logic        cs    [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        rvalid[2];
  logic        wreq  [2];
  logic        creq  [2];
  logic        busy  [2];

  int tests = 0;
  int fails = 0;
  int c0, c1, vc, lat;

  avalon_onchip_ram_clr #(
    .DATA_W(32), .ADDR_W(4), .DEPTH(16), .READ_LATENCY(1),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h0000_0000)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(addr[0]), .byteenable(be[0]),
    .chipselect(cs[0]), .read(rd[0]), .write(wr[0]), .writedata(wdata[0]),
    .readdata(rdata[0]), .readdatavalid(rvalid[0]), .waitrequest(wreq[0]),
    .clear_req(creq[0]), .clear_busy(busy[0])
  );

  avalon_onchip_ram_clr #(
    .DATA_W(32), .ADDR_W(4), .DEPTH(12), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(32'h1234_5678)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(addr[1]), .byteenable(be[1]),
    .chipselect(cs[1]), .read(rd[1]), .write(wr[1]), .writedata(wdata[1]),
    .readdata(rdata[1]), .readdatavalid(rvalid[1]), .waitrequest(wreq[1]),
    .clear_req(creq[1]), .clear_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    cs[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0; creq[d] = 1'b0;
  endtask

  task automatic wait_ready(input int d, input string tag);
    int n;
    n = 0;
    while (wreq[d] && n < 64) begin tick(); n++; end
    check({tag, "_ready"}, 32'(wreq[d]), 32'h0);
  endtask

  task automatic do_write(input int d, input int a, input logic [31:0] data, input logic [3:0] b);
    cs[d] = 1'b1; wr[d] = 1'b1; rd[d] = 1'b0;
    addr[d] = 4'(a); be[d] = b; wdata[d] = data;
    wait_ready(d, $sformatf("wr%0d_a%0d", d, a));
    tick();
    idle(d);
  endtask

  task automatic do_read(input int d, input int a, input logic [31:0] exp, input string tag);
    int l;
    cs[d] = 1'b1; rd[d] = 1'b1; wr[d] = 1'b0; addr[d] = 4'(a);
    wait_ready(d, tag);
    tick();
    idle(d);
    l = 1;
    while (!rvalid[d] && l < 8) begin tick(); l++; end
    check({tag, "_lat"}, 32'(l), (d == 0) ? 32'd1 : 32'd2);
    check({tag, "_data"}, rdata[d], exp);
  endtask

  // Samples 40 cycles, counting busy cycles per DUT and readdatavalid pulses.
  task automatic count_window(output int n0, output int n1, output int nv);
    n0 = 0; n1 = 0; nv = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy[0]) n0++;
      if (busy[1]) n1++;
      if (rvalid[0] || rvalid[1]) nv++;
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      idle(d); addr[d] = '0; be[d] = '0; wdata[d] = '0;
    end
    tick(); tick(); tick();

    // Reset state
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_busy", d),  32'(busy[d]),   32'h1);
      check($sformatf("rst%0d_wreq", d),  32'(wreq[d]),   32'h1);
      check($sformatf("rst%0d_valid", d), 32'(rvalid[d]), 32'h0);
      check($sformatf("rst%0d_rdata", d), rdata[d],       32'h0);
    end

    // Clear on reset release lasts DEPTH cycles
    reset_n = 1'b1;
    count_window(c0, c1, vc);
    check("clr_rst_len0", 32'(c0), 32'd16);
    check("clr_rst_len1", 32'(c1), 32'd12);
    for (int a = 0; a < 16; a++) do_read(0, a, 32'h0, $sformatf("init0_a%0d", a));
    for (int a = 0; a < 12; a++) do_read(1, a, 32'h1234_5678, $sformatf("init1_a%0d", a));

    // Byte-lane writes, then read-after-write
    for (int d = 0; d < 2; d++) begin
      do_write(d, 3, 32'hDEAD_BEEF, 4'b1111);
      do_write(d, 3, 32'h0011_0000, 4'b0100);
      do_read(d, 3, 32'hDE11_BEEF, $sformatf("be%0d", d));
    end

    // Back-to-back reads on both DUTs
    for (int i = 0; i < 4; i++) begin
      do_write(0, i, 32'hA0 + i, 4'hF);
      do_write(1, i, 32'hA0 + i, 4'hF);
    end
    for (int i = 0; i < 7; i++) begin
      for (int d = 0; d < 2; d++) begin
        cs[d] = (i < 4); rd[d] = (i < 4); wr[d] = 1'b0; addr[d] = 4'(i);
      end
      tick();
      check($sformatf("b2b0_v%0d", i), 32'(rvalid[0]), 32'(i < 4));
      if (i < 4) check($sformatf("b2b0_d%0d", i), rdata[0], 32'hA0 + i);
      check($sformatf("b2b1_v%0d", i), 32'(rvalid[1]), 32'(i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) check($sformatf("b2b1_d%0d", i), rdata[1], 32'hA0 + i - 1);
    end
    idle(0); idle(1);
    check("hold0", rdata[0], 32'hA3);
    check("hold1", rdata[1], 32'hA3);

    // Read presented with clear_req is served with pre-clear data
    cs[0] = 1'b1; rd[0] = 1'b1; addr[0] = 4'd3; creq[0] = 1'b1;
    tick();
    idle(0);
    check("preclr_valid", 32'(rvalid[0]), 32'h1);
    check("preclr_data", rdata[0], 32'hA3);
    count_window(c0, c1, vc);
    check("clr_req_len0", 32'(c0), 32'd16);
    check("clr_req_idle1", 32'(c1), 32'd0);
    check("clr_req_vcnt", 32'(vc), 32'd1);
    do_read(0, 3, 32'h0, "postclr0_a3");
    do_read(0, 0, 32'h0, "postclr0_a0");

    // Held read during clear with a second clear_req mid-sequence
    for (int a = 0; a < 12; a++) do_write(1, a, 32'h5555_5555, 4'hF);
    creq[1] = 1'b1;
    tick();
    creq[1] = 1'b0;
    cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 4'd7;
    c1 = 0;
    while (wreq[1] && c1 < 40) begin
      c1++;
      creq[1] = (c1 == 5);
      tick();
    end
    creq[1] = 1'b0;
    check("clr_held_len1", 32'(c1), 32'd12);
    tick();
    idle(1);
    lat = 1;
    while (!rvalid[1] && lat < 8) begin tick(); lat++; end
    check("held_rd_lat", 32'(lat), 32'd2);
    check("held_rd_data", rdata[1], 32'h1234_5678);
    do_read(1, 0, 32'h1234_5678, "clr1_a0");

    // Reset mid-clear (dut0 at clr_addr=5) and mid-read (dut1)
    do_write(0, 0, 32'h1111_1111, 4'hF);
    do_write(0, 15, 32'h1111_1111, 4'hF);
    creq[0] = 1'b1;
    tick();
    creq[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin cs[1] = 1'b1; rd[1] = 1'b1; addr[1] = 4'd2; end
      tick();
    end
    idle(1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy0", 32'(busy[0]), 32'h1);
    check("mid_rst_busy1", 32'(busy[1]), 32'h1);
    check("mid_rst_rdata1", rdata[1], 32'h0);
    check("mid_rst_valid1", 32'(rvalid[1]), 32'h0);
    tick(); tick();
    check("mid_rst_flush1", 32'(rvalid[1]), 32'h0);
    reset_n = 1'b1;
    count_window(c0, c1, vc);
    check("rst_restart_len0", 32'(c0), 32'd16);
    check("rst_restart_len1", 32'(c1), 32'd12);
    check("rst_lost_reads", 32'(vc), 32'd0);
    do_read(0, 0, 32'h0, "rst0_a0");
    do_read(0, 15, 32'h0, "rst0_a15");

    // Out-of-range access on the 12-word instance
    do_write(1, 13, 32'hFFFF_FFFF, 4'hF);
    do_read(1, 13, 32'h0, "oor1_a13");
    for (int a = 0; a < 12; a++) do_read(1, a, 32'h1234_5678, $sformatf("oor1_a%0d", a));

    // read & write together is a write only; byteenable=0 writes nothing
    cs[0] = 1'b1; rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 4'd4;
    be[0] = 4'hF; wdata[0] = 32'h0BAD_F00D;
    tick();
    idle(0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rw_novalid%0d", k), 32'(rvalid[0]), 32'h0);
      tick();
    end
    do_read(0, 4, 32'h0BAD_F00D, "rw0_a4");
    do_write(0, 4, 32'hFFFF_FFFF, 4'b0000);
    do_read(0, 4, 32'h0BAD_F00D, "be0_none");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
